// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: central pipeline controller. Produces per-stage stall and
// flush controls, operand forwarding selects, mul/div occupancy tracking and a
// saturating stall-cycle counter. Resolution order: memory wait, mul/div
// occupancy, taken branch, load-use.
module hazard_stall_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             im_req,
  input  logic             im_ready,
  input  logic             dm_req,
  input  logic             dm_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             stall_wb,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_mem,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MD_CW = ($clog2(MD_LATENCY) < 3) ? 3 : $clog2(MD_LATENCY);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t           state, state_nxt;
  logic [MD_CW-1:0] md_cnt, md_cnt_nxt;
  logic             mem_wait;
  logic             md_stall;
  logic             md_last;
  logic             load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs))
      return 2'd1;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs))
      return 2'd2;
    else
      return 2'd0;
  endfunction

  assign mem_wait = (im_req && !im_ready) || (dm_req && !dm_ready);
  assign md_last  = (state == MD_BUSY) && (md_cnt == '0);
  assign md_stall = ((state == RUN) && ex_md_start) ||
                    ((state == MD_BUSY) && (md_cnt != '0));
  assign load_use = ex_mem_read && ex_reg_write && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // State register: FSM state and mul/div down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Next-state: memory waits freeze the sequencer; otherwise count down occupancy
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    if (!mem_wait) begin
      case (state)
        RUN: begin
          if (ex_md_start) begin
            state_nxt  = MD_BUSY;
            md_cnt_nxt = MD_CW'(MD_LATENCY - 2);
          end
        end
        MD_BUSY: begin
          if (md_cnt != '0)
            md_cnt_nxt = md_cnt - MD_CW'(1);
          else
            state_nxt = RUN;
        end
        default: begin
          state_nxt  = RUN;
          md_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Outputs: prioritized stall/flush resolution plus forwarding, all zero in reset
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    stall_wb    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    flush_mem   = 1'b0;
    md_done     = 1'b0;
    fwd_rs1_sel = 2'd0;
    fwd_rs2_sel = 2'd0;
    if (!rst) begin
      fwd_rs1_sel = fwd_sel(id_rs1);
      fwd_rs2_sel = fwd_sel(id_rs2);
      if (mem_wait) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        stall_wb  = 1'b1;
      end else if (md_stall) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        flush_mem = 1'b1;
      end else begin
        md_done = md_last;
        if (ex_branch_taken) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end
    end
  end

  // Performance counter: cycles with the front end held, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (stall_if && (stall_count != '1))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: two instances (MD_LATENCY=4/CNT_W=32 and
// MD_LATENCY=3/CNT_W=4) share stimulus and are compared every cycle against a
// rule-level reference model that tracks mul/div age in elapsed EX cycles.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_rs1_used, id_rs2_used, ex_reg_write, ex_mem_read;
  logic       mem_reg_write, wb_reg_write, ex_branch_taken, ex_md_start;
  logic       im_req, im_ready, dm_req, dm_ready;

  logic [4:0]  a_stall, b_stall;
  logic [2:0]  a_flush, b_flush;
  logic [1:0]  a_fwd1, a_fwd2, b_fwd1, b_fwd2;
  logic        a_done, b_done;
  logic [31:0] a_cnt;
  logic [3:0]  b_cnt;

  wire [12:0] obs_a = {a_stall, a_flush, a_fwd1, a_fwd2, a_done};
  wire [12:0] obs_b = {b_stall, b_flush, b_fwd1, b_fwd2, b_done};

  int          age_a, age_b;
  logic [31:0] m_cnt_a;
  logic [3:0]  m_cnt_b;
  logic [12:0] exp_a, exp_b;
  int          total, passed;

  hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .im_req(im_req), .im_ready(im_ready), .dm_req(dm_req), .dm_ready(dm_ready),
    .stall_if(a_stall[4]), .stall_id(a_stall[3]), .stall_ex(a_stall[2]),
    .stall_mem(a_stall[1]), .stall_wb(a_stall[0]), .flush_id(a_flush[2]),
    .flush_ex(a_flush[1]), .flush_mem(a_flush[0]), .fwd_rs1_sel(a_fwd1),
    .fwd_rs2_sel(a_fwd2), .md_done(a_done), .stall_count(a_cnt)
  );

  hazard_stall_ctrl #(.MD_LATENCY(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .im_req(im_req), .im_ready(im_ready), .dm_req(dm_req), .dm_ready(dm_ready),
    .stall_if(b_stall[4]), .stall_id(b_stall[3]), .stall_ex(b_stall[2]),
    .stall_mem(b_stall[1]), .stall_wb(b_stall[0]), .flush_id(b_flush[2]),
    .flush_ex(b_flush[1]), .flush_mem(b_flush[0]), .fwd_rs1_sel(b_fwd1),
    .fwd_rs2_sel(b_fwd2), .md_done(b_done), .stall_count(b_cnt)
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'd1;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic ref_mem_wait();
    return (im_req && !im_ready) || (dm_req && !dm_ready);
  endfunction

  // age = number of completed EX cycles of the mul/div currently in EX (0 = none)
  function automatic logic [12:0] model_out(input int lat, input int age);
    logic [4:0] s;
    logic [2:0] f;
    logic       d, lu;
    int         cyc;
    s = '0; f = '0; d = 1'b0;
    if (rst) return 13'd0;
    cyc = (age > 0) ? age + 1 : (ex_md_start ? 1 : 0);
    lu  = ex_mem_read && ex_reg_write && ex_rd != 0 &&
          ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    if (ref_mem_wait()) s = 5'b11111;
    else if (cyc != 0 && cyc < lat) begin s = 5'b11100; f = 3'b001; end
    else begin
      d = (cyc == lat);
      if (ex_branch_taken) f = 3'b110;
      else if (lu) begin s = 5'b11000; f = 3'b010; end
    end
    return {s, f, ref_fwd(id_rs1), ref_fwd(id_rs2), d};
  endfunction

  function automatic int next_age(input int lat, input int age);
    if (ref_mem_wait()) return age;
    if (age > 0) return (age + 1 == lat) ? 0 : age + 1;
    return ex_md_start ? 1 : 0;
  endfunction

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_reg_write = 0; wb_reg_write = 0; ex_branch_taken = 0; ex_md_start = 0;
    im_req = 0; im_ready = 0; dm_req = 0; dm_ready = 0;
  endtask

  // Let combinational outputs settle, apply async reset to the model, compute expectations
  task automatic settle();
    #1;
    if (rst) begin age_a = 0; age_b = 0; m_cnt_a = 0; m_cnt_b = 0; end
    exp_a = model_out(4, age_a);
    exp_b = model_out(3, age_b);
  endtask

  // Advance the model across one rising edge using the inputs held across it
  task automatic step();
    logic [12:0] ea, eb;
    @(posedge clk);
    if (!rst) begin
      ea = model_out(4, age_a);
      eb = model_out(3, age_b);
      if (ea[12] && m_cnt_a != '1) m_cnt_a = m_cnt_a + 1;
      if (eb[12] && m_cnt_b != 4'hF) m_cnt_b = m_cnt_b + 1;
      age_a = next_age(4, age_a);
      age_b = next_age(3, age_b);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; ex_md_start = 1; dm_req = 1; ex_branch_taken = 1;
    mem_reg_write = 1; mem_rd = 3; id_rs1 = 3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); settle();
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b || a_cnt !== m_cnt_a || b_cnt !== m_cnt_b)
        $display("[TB] FAIL reset: got a=%b/%0d b=%b/%0d, required a=%b/%0d b=%b/%0d",
                 obs_a, a_cnt, obs_b, b_cnt, exp_a, m_cnt_a, exp_b, m_cnt_b);
      else passed++;
      step();
    end
    @(negedge clk); rst = 0; clear_inputs();
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); clear_inputs();
      id_rs1 = 5; id_rs1_used = 1;
      case (c)
        0: begin ex_rd = 5; ex_reg_write = 1; ex_mem_read = 1; end
        1: begin mem_rd = 5; mem_reg_write = 1; end
        default: begin id_rs1 = 0; ex_rd = 0; ex_reg_write = 1; ex_mem_read = 1; end
      endcase
      settle();
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b || a_cnt !== m_cnt_a || b_cnt !== m_cnt_b)
        $display("[TB] FAIL load_use c%0d: got a=%b/%0d b=%b/%0d, required a=%b/%0d b=%b/%0d",
                 c, obs_a, a_cnt, obs_b, b_cnt, exp_a, m_cnt_a, exp_b, m_cnt_b);
      else passed++;
      step();
    end
  endtask

  task automatic test_md();
    int stalls, done_cyc;
    logic [31:0] cnt0;
    stalls = 0; done_cyc = 0; cnt0 = a_cnt;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); clear_inputs();
      ex_md_start = (c <= 4);
      settle();
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b || a_cnt !== m_cnt_a || b_cnt !== m_cnt_b)
        $display("[TB] FAIL md c%0d: got a=%b/%0d b=%b/%0d, required a=%b/%0d b=%b/%0d",
                 c, obs_a, a_cnt, obs_b, b_cnt, exp_a, m_cnt_a, exp_b, m_cnt_b);
      else passed++;
      if (a_stall[2] && a_flush[0]) stalls++;
      if (a_done && done_cyc == 0) done_cyc = c;
      step();
    end
    total++;
    if (stalls != 3 || done_cyc != 4 || a_cnt - cnt0 != 32'd3)
      $display("[TB] FAIL md_shape: got stalls=%0d done_cyc=%0d cnt_delta=%0d, required 3/4/3",
               stalls, done_cyc, a_cnt - cnt0);
    else passed++;
  endtask

  task automatic test_md_wait();
    int done_cyc;
    done_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); clear_inputs();
      ex_md_start = (c <= 9);
      dm_req = (c >= 3 && c <= 7);
      settle();
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b || a_cnt !== m_cnt_a || b_cnt !== m_cnt_b)
        $display("[TB] FAIL md_wait c%0d: got a=%b/%0d b=%b/%0d, required a=%b/%0d b=%b/%0d",
                 c, obs_a, a_cnt, obs_b, b_cnt, exp_a, m_cnt_a, exp_b, m_cnt_b);
      else passed++;
      if (a_done && done_cyc == 0) done_cyc = c;
      step();
    end
    total++;
    if (done_cyc != 9)
      $display("[TB] FAIL md_wait_done: got done cycle %0d, required 9", done_cyc);
    else passed++;
  endtask

  task automatic test_branch_load_use();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); clear_inputs();
      ex_rd = 9; ex_reg_write = 1; ex_mem_read = 1; id_rs2 = 9; id_rs2_used = 1;
      ex_branch_taken = (c == 0);
      settle();
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b || a_cnt !== m_cnt_a || b_cnt !== m_cnt_b ||
          (c == 0 && (a_stall[4] !== 1'b0 || a_flush[2:1] !== 2'b11)))
        $display("[TB] FAIL branch_lu c%0d: got a=%b/%0d b=%b/%0d, required a=%b/%0d b=%b/%0d",
                 c, obs_a, a_cnt, obs_b, b_cnt, exp_a, m_cnt_a, exp_b, m_cnt_b);
      else passed++;
      step();
    end
  endtask

  task automatic test_forwarding();
    logic [1:0] want;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); clear_inputs();
      mem_rd = (c == 2) ? 5'd0 : 5'd7; wb_rd = mem_rd;
      id_rs2 = mem_rd; id_rs2_used = 1;
      mem_reg_write = (c != 1); wb_reg_write = 1;
      want = (c == 0) ? 2'd1 : (c == 1) ? 2'd2 : 2'd0;
      settle();
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b || a_fwd2 !== want)
        $display("[TB] FAIL forwarding c%0d: got a=%b fwd2=%0d, required a=%b fwd2=%0d",
                 c, obs_a, a_fwd2, exp_a, want);
      else passed++;
      step();
    end
  endtask

  task automatic test_reset_mid_md();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); clear_inputs();
      ex_md_start = (c <= 2 || c == 5);
      rst = (c == 2 || c == 3);
      settle();
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b || a_cnt !== m_cnt_a || b_cnt !== m_cnt_b ||
          (rst && obs_a !== 13'd0))
        $display("[TB] FAIL reset_mid_md c%0d: got a=%b/%0d b=%b/%0d, required a=%b/%0d b=%b/%0d",
                 c, obs_a, a_cnt, obs_b, b_cnt, exp_a, m_cnt_a, exp_b, m_cnt_b);
      else passed++;
      step();
    end
  endtask

  task automatic test_saturation();
    @(negedge clk); clear_inputs(); rst = 1;
    settle(); step();
    @(negedge clk); rst = 0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk); clear_inputs();
      if (c < 18) im_req = 1;
      settle();
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b || a_cnt !== m_cnt_a || b_cnt !== m_cnt_b)
        $display("[TB] FAIL saturation c%0d: got a=%b/%0d b=%b/%0d, required a=%b/%0d b=%b/%0d",
                 c, obs_a, a_cnt, obs_b, b_cnt, exp_a, m_cnt_a, exp_b, m_cnt_b);
      else passed++;
      step();
    end
    total++;
    if (b_cnt !== 4'd15 || a_cnt !== 32'd18)
      $display("[TB] FAIL saturation_end: got b=%0d a=%0d, required b=15 a=18", b_cnt, a_cnt);
    else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 49) == 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
      mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      ex_md_start = ($urandom_range(0, 3) == 0);
      im_req = 1'($urandom); im_ready = ($urandom_range(0, 3) != 0);
      dm_req = 1'($urandom); dm_ready = ($urandom_range(0, 3) != 0);
      settle();
      total++;
      if (obs_a !== exp_a || obs_b !== exp_b || a_cnt !== m_cnt_a || b_cnt !== m_cnt_b)
        $display("[TB] FAIL random c%0d: got a=%b/%0d b=%b/%0d, required a=%b/%0d b=%b/%0d",
                 c, obs_a, a_cnt, obs_b, b_cnt, exp_a, m_cnt_a, exp_b, m_cnt_b);
      else passed++;
      step();
    end
    @(negedge clk); rst = 0; clear_inputs();
  endtask

  // Test sequence
  initial begin
    total = 0; passed = 0;
    age_a = 0; age_b = 0; m_cnt_a = 0; m_cnt_b = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_md();
    test_md_wait();
    test_branch_load_use();
    test_forwarding();
    test_reset_mid_md();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Central pipeline controller for the 5-stage CPU core: it produces the per-stage `Stall`/flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, and the 2-bit forwarding selects that travel with each stage as `*_Hazard`. It resolves memory wait-states, multi-cycle mul/div occupancy, taken branches and load-use hazards with a fixed priority. It also keeps a saturating stall-cycle performance counter.

## Interface
- `MD_LATENCY`, 4: total cycles a mul/div instruction occupies EX; legal range ≥2.
- `CNT_W`, 32: width of `stall_count`.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the ID instruction reads that source.
- `ex_rd`  in  5  destination register in EX.
- `ex_reg_write`, `ex_mem_read`  in  1 each  EX writes rd / EX is a load.
- `mem_rd`  in  5  destination register in MEM.
- `mem_reg_write`  in  1  MEM writes rd.
- `wb_rd`  in  5  destination register in WB.
- `wb_reg_write`  in  1  WB writes rd.
- `ex_branch_taken`  in  1  EX resolved a taken branch or jump.
- `ex_md_start`  in  1  EX holds a mul/div instruction.
- `im_req`, `im_ready`  in  1 each  instruction-memory request / data valid.
- `dm_req`, `dm_ready`  in  1 each  data-memory request / done.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem`, `stall_wb`  out  1 each  hold the corresponding stage register.
- `flush_id`, `flush_ex`, `flush_mem`  out  1 each  load a bubble into that stage register.
- `fwd_rs1_sel`, `fwd_rs2_sel`  out  2 each  0 = register file, 1 = from MEM, 2 = from WB; 3 is never driven.
- `md_done`  out  1  last EX cycle of a mul/div.
- `stall_count`  out  CNT_W  cycles with `stall_if` = 1, saturating.

## Operation
- Define `mem_wait` = (`im_req` & !`im_ready`) | (`dm_req` & !`dm_ready`).
- FSM states:
  - RUN: default state.
  - MD_BUSY: holds a 3-bit-or-wider down-counter `md_cnt`.
- Priority, highest first; a lower rule is suppressed in any cycle where a higher rule applies:
  1. `mem_wait`: all five `stall_*` = 1, all flushes = 0. FSM state and `md_cnt` hold.
  2. MD occupancy: `stall_if`/`stall_id`/`stall_ex` = 1 and `flush_mem` = 1.
     - In RUN with `ex_md_start` = 1, the FSM enters MD_BUSY and loads `md_cnt` = MD_LATENCY-2; this is the start cycle.
     - In MD_BUSY with `md_cnt` ≠ 0, `md_cnt` decrements each cycle.
     - In MD_BUSY with `md_cnt` = 0: no MD stall, `md_done` = 1, next state RUN. `ex_md_start` is ignored in that cycle, because the instruction advances.
     - Net effect: EX holds the instruction exactly MD_LATENCY cycles, of which MD_LATENCY-1 are stalled.
  3. Taken branch: `flush_id` = 1 and `flush_ex` = 1; no stalls.
  4. Load-use: condition is `ex_mem_read` & `ex_reg_write` & `ex_rd` ≠ 0 & ((`id_rs1_used` & `id_rs1` == `ex_rd`) | (`id_rs2_used` & `id_rs2` == `ex_rd`)).
     - Response: `stall_if` = `stall_id` = 1 and `flush_ex` = 1, for one cycle.
- Forwarding, per source, independent of stalls:
  - MEM match (`mem_reg_write`, `mem_rd` ≠ 0, `mem_rd` == `id_rsX`) → 1.
  - Else WB match (same conditions on `wb_rd`) → 2.
  - Else → 0.
  - MEM has priority over WB. Register x0 never forwards.
- `stall_count` increments when `stall_if` = 1 and holds at all-ones.

## Timing
- All stall, flush, forwarding and `md_done` outputs are combinational from the inputs, the FSM state and `md_cnt`. There is no added latency; they are valid in the same cycle the condition appears.
- Only the FSM state, `md_cnt` and `stall_count` are registered.
- Reset (async, including mid-operation):
  - State → RUN, `md_cnt` → 0, `stall_count` → 0.
  - While `rst` = 1, all `stall_*`, `flush_*`, `md_done` = 0 and `fwd_*_sel` = 0.
- Simultaneous events:
  - A branch arriving during `mem_wait` or MD stall is not lost: EX is frozen, so it re-presents when the stall releases.
  - `ex_md_start` during `mem_wait` in RUN does not start the counter; it starts in the first non-wait cycle.
  - `mem_wait` on the MD_BUSY `md_cnt` = 0 cycle suppresses `md_done` until the wait clears.

## Test plan
- Load `x5` in EX, ID reads `rs1` = 5 → exactly one cycle with `stall_if` = `stall_id` = `flush_ex` = 1, then `fwd_rs1_sel` = 1 the next cycle; the same sequence with `ex_rd` = 0 → no stall.
- `ex_md_start` held with MD_LATENCY = 4 → 3 cycles of `stall_ex` = `flush_mem` = 1, `md_done` = 1 on cycle 4, state returns to RUN; `stall_count` += 3.
- `dm_req` = 1 with `dm_ready` low for 5 cycles in the middle of an MD_BUSY sequence → all stalls = 1 for 5 cycles, `md_cnt` frozen, `md_done` delayed by 5.
- `ex_branch_taken` together with a load-use condition → `flush_id` = `flush_ex` = 1, `stall_if` = 0.
- `mem_rd` = `wb_rd` = 7, both writing, `id_rs2` = 7 → `fwd_rs2_sel` = 1; with `mem_reg_write` = 0 → 2; with `rd` = 0 → 0.
- Assert `rst` mid-MD_BUSY → all outputs 0 immediately, RUN after release; then force 2^CNT_W stalls with CNT_W = 4 → `stall_count` saturates at 15.
